mux_2_1_arbiter: RTL and testbench
==================================

Name: mux_2_1_arbiter

Overview:
- Round-robin arbiter that shares one DATA_WIDTH output channel between two requesters, using the 2:1 select datapath.
- Owns and sequences the mux select. Two requesters never drive the shared output at the same time.
- Grants are burst-locked: a grant is held until the requester's last beat, or until MAX_BURST beats have been accepted.
- Sits between two producer streams (for example two buffer readers) and a single downstream consumer; the output is a registered one-entry stage.

Parameters:
- DATA_WIDTH, 8, width of each data beat.
- MAX_BURST, 16, maximum beats per grant before forced release; legal range 1..255.
- INIT_PRIO, 0, requester that wins the first contested arbitration after reset (0 or 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in0_valid  in  1  requester 0 beat valid.
- in0_data  in  DATA_WIDTH  requester 0 beat data.
- in0_last  in  1  requester 0 final beat of burst.
- in0_ready  out  1  requester 0 beat accepted this cycle when in0_valid && in0_ready.
- in1_valid  in  1  requester 1 beat valid.
- in1_data  in  DATA_WIDTH  requester 1 beat data.
- in1_last  in  1  requester 1 final beat of burst.
- in1_ready  out  1  requester 1 beat accepted this cycle when in1_valid && in1_ready.
- out_valid  out  1  registered output beat valid.
- out_data  out  DATA_WIDTH  registered output data.
- out_last  out  1  registered last flag (in_last, or forced-release beat).
- out_src  out  1  source of the current output beat (the mux select value).
- out_ready  in  1  downstream accept.
- busy  out  1  a grant is active (state != IDLE).

Behaviour:
- Reset (async assert, sync deassert to clk):
  - state = IDLE, prio = INIT_PRIO, beat_cnt = 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_src = 0, in0_ready = 0, in1_ready = 0, busy = 0.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - If exactly one inX_valid is high, go to GRANTX next cycle.
  - If both are high, go to GRANT[prio].
  - No beat is accepted in IDLE. Arbitration costs one cycle.
- GRANTX:
  - inX_ready = (!out_valid || out_ready). The other requester's ready = 0.
  - The ready signals are combinational from state/out_valid/out_ready and never depend on inX_valid.
- Accept in GRANTX (inX_valid && inX_ready):
  - out_data <= inX_data, out_src <= X, out_valid <= 1.
  - out_last <= inX_last || (beat_cnt == MAX_BURST-1).
  - beat_cnt <= beat_cnt + 1.
- Release: when the accepted beat has out_last set, then next cycle:
  - beat_cnt <= 0, prio <= ~X, state <= IDLE.
- Output register:
  - If out_valid && !out_ready, out_* hold stable; no new accept is possible.
  - If out_ready is high with no accept, out_valid <= 0.
  - Accept and drain in the same cycle sustain 1 beat/cycle.
- Latency: input accept to out_valid is 1 cycle. Request in IDLE to first accept is 1 cycle. Minimum gap between bursts from different requesters is 1 idle cycle.
- Prio updates only on release. An uncontested requester can be granted repeatedly; prio still toggles after each of its bursts.
- MAX_BURST = 1: every beat is a forced release; requesters alternate beat by beat under contention.
- beat_cnt is 8 bits and never wraps past MAX_BURST-1.
- Valid deassertion mid-burst: the grant is held (no release) until the burst ends.
- Reset mid-burst: all state clears immediately; any in-flight out beat is dropped.

Test Plan:
- Only in0 sends 3 beats (data 0xF0, 0xF1, 0xF2, last on the 3rd), out_ready = 1:
  - out shows 0xF0, 0xF1, 0xF2 on consecutive cycles with out_src = 0 and out_last on 0xF2.
  - First out_valid appears 2 cycles after in0_valid rises.
  - busy drops after release.
- Both valid from reset, INIT_PRIO = 0, each burst 2 beats (in0: 0xF0, 0xF1; in1: 0x0F, 0x0E):
  - Order is 0xF0, 0xF1, (1 idle), 0x0F, 0x0E, with out_src 0, 0, 1, 1.
  - in1_ready is never high during GRANT0.
- MAX_BURST = 4, in0 streams 10 beats with no last while in1 is valid:
  - Beat 4 has out_last = 1 (forced), then in1 is granted.
  - in0 resumes after in1's burst.
- out_ready held low for 3 cycles mid-burst:
  - out_data/out_last/out_src stay stable.
  - in0_ready = 0 for those cycles.
  - No beat is lost or duplicated (sequence 0x01..0x05 arrives intact).
- Assert reset_n low during the 2nd beat of a GRANT1 burst:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, an in0-only request is granted with out_src = 0.

Source files
------------

// File: rtl/mux_2_1_arbiter.sv
// mux_2_1_arbiter: round-robin, burst-locked arbiter sharing one registered
// output channel between two requesters through a 2:1 select datapath.
//
// Handshake: a beat moves on an input when inX_valid && inX_ready on a rising
// clk edge, and on the output when out_valid && out_ready. Readys come only from
// state/out_valid/out_ready, never from inX_valid. Once out_valid is high, the
// out_* fields stay stable until out_ready accepts the beat.
module mux_2_1_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int INIT_PRIO  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in0_valid,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in0_last,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_last,
    output logic                  in1_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_src,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Beat index of the final beat allowed in one grant.
    localparam logic [7:0] LAST_CNT  = 8'(MAX_BURST - 1);
    localparam logic       PRIO_INIT = 1'(INIT_PRIO);

    state_t                state;
    logic                  prio;
    logic [7:0]            beat_cnt;

    logic                  can_load;
    logic                  acc0;
    logic                  acc1;
    logic                  accept;
    logic                  sel;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;
    logic                  beat_last;

    // Ready, accept and the 2:1 select path for the granted requester.
    always_comb begin
        can_load  = !out_valid || out_ready;
        in0_ready = (state == GRANT0) && can_load;
        in1_ready = (state == GRANT1) && can_load;
        acc0      = in0_valid && in0_ready;
        acc1      = in1_valid && in1_ready;
        accept    = acc0 || acc1;
        sel       = acc1;
        sel_data  = sel ? in1_data : in0_data;
        sel_last  = sel ? in1_last : in0_last;
        beat_last = sel_last || (beat_cnt == LAST_CNT);
        busy      = (state != IDLE);
    end

    // Arbitration FSM: pick a requester in IDLE, hold the grant until a last
    // (real or forced) beat is accepted, then hand priority to the other side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prio     <= PRIO_INIT;
            beat_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0_valid && in1_valid) begin
                        state <= prio ? GRANT1 : GRANT0;
                    end else if (in0_valid) begin
                        state <= GRANT0;
                    end else if (in1_valid) begin
                        state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
                        if (beat_last) begin
                            state    <= IDLE;
                            beat_cnt <= 8'd0;
                            prio     <= ~sel;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-entry output stage: load on accept, clear valid when drained idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= beat_last;
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// Bench for mux_2_1_arbiter: a cycle table on the default build, then
// multi-cycle sequences for forced release, back-pressure and mid-burst reset.
module tb_mux_2_1_arbiter;

    logic       clk;
    logic       reset_n;
    logic       in0_valid, in0_last, in1_valid, in1_last, out_ready;
    logic [7:0] in0_data, in1_data;

    logic       in0_ready, in1_ready, out_valid, out_last, out_src, busy;
    logic [7:0] out_data;
    logic       in0_ready4, in1_ready4, out_valid4, out_last4, out_src4, busy4;
    logic [7:0] out_data4;

    int checks   = 0;
    int failures = 0;

    mux_2_1_arbiter #(.DATA_WIDTH(8), .MAX_BURST(16), .INIT_PRIO(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .busy(busy)
    );

    mux_2_1_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4), .INIT_PRIO(0)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready4),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_last(out_last4), .out_src(out_src4),
        .out_ready(out_ready), .busy(busy4)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic       e_os;
        logic       e_r0;
        logic       e_r1;
        logic       e_b;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    function automatic vec_t mk(
        input logic rst_n, input logic v0, input logic [7:0] d0, input logic l0,
        input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
        input logic e_ov, input logic [7:0] e_od, input logic e_ol, input logic e_os,
        input logic e_r0, input logic e_r1, input logic e_b);
        vec_t v;
        v.rst_n = rst_n; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_os = e_os;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_b = e_b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        in0_valid = 1'b0; in0_data = 8'h00; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard: compare collected output beats {src,last,data} with exp_q.
    task automatic score(input string name);
        check({name, " count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [9:0] e, g;
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({name, " beat"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();

        // Cycle table: rst,v0,d0,l0,v1,d1,l1,ordy | ov,od,ol,os,r0,r1,busy
        // Single in0 burst of three beats.
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hF0, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hF0, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 8'hF1, 0, 0, 8'h00, 0, 1,  1, 8'hF0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 8'hF2, 1, 0, 8'h00, 0, 1,  1, 8'hF1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 8'hF2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'hF2, 1, 0, 0, 0, 0));
        // Contested: both valid from reset, two-beat bursts each.
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hF0, 0, 1, 8'h0F, 0, 1,  0, 8'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hF0, 0, 1, 8'h0F, 0, 1,  0, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 8'hF1, 1, 1, 8'h0F, 0, 1,  1, 8'hF0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h0F, 0, 1,  1, 8'hF1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h0F, 0, 1,  0, 8'hF1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h0E, 1, 1,  1, 8'h0F, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 8'h0E, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 8'h0E, 1, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n   = vecs[i].rst_n;
            in0_valid = vecs[i].v0; in0_data = vecs[i].d0; in0_last = vecs[i].l0;
            in1_valid = vecs[i].v1; in1_data = vecs[i].d1; in1_last = vecs[i].l1;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("row%0d out_valid", i), out_valid, vecs[i].e_ov);
            check($sformatf("row%0d out_data", i),  out_data,  vecs[i].e_od);
            check($sformatf("row%0d out_last", i),  out_last,  vecs[i].e_ol);
            check($sformatf("row%0d out_src", i),   out_src,   vecs[i].e_os);
            check($sformatf("row%0d in0_ready", i), in0_ready, vecs[i].e_r0);
            check($sformatf("row%0d in1_ready", i), in1_ready, vecs[i].e_r1);
            check($sformatf("row%0d busy", i),      busy,      vecs[i].e_b);
        end

        // MAX_BURST=4: in0 streams 10 beats without last while in1 waits.
        do_reset();
        begin
            int  k0 = 0, k1 = 0, both_rdy = 0;
            logic a0, a1, done;
            done = 1'b0;
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, (i == 3), 8'(8'h10 + i)});
            exp_q.push_back({1'b1, 1'b0, 8'hA0});
            exp_q.push_back({1'b1, 1'b1, 8'hA1});
            for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, (i == 7), 8'(8'h10 + i)});
            exp_q.push_back({1'b0, 1'b0, 8'h18});
            exp_q.push_back({1'b0, 1'b0, 8'h19});
            for (int cyc = 0; cyc < 80 && !done; cyc++) begin
                in0_valid = (k0 < 10); in0_data = 8'(8'h10 + k0); in0_last = 1'b0;
                in1_valid = (k1 < 2);  in1_data = 8'(8'hA0 + k1); in1_last = (k1 == 1);
                #1;
                if (out_valid4) got_q.push_back({out_src4, out_last4, out_data4});
                if (in0_ready4 && in1_ready4) both_rdy++;
                a0 = in0_valid && in0_ready4;
                a1 = in1_valid && in1_ready4;
                if (k0 == 10 && k1 == 2 && !out_valid4) done = 1'b1;
                @(negedge clk);
                if (a0) k0++;
                if (a1) k1++;
            end
            check("max4 finished", done, 1'b1);
            check("max4 ready exclusive", both_rdy, 0);
            check("max4 grant held after valid drop", busy4, 1'b1);
            score("max4");
        end

        // Back-pressure: out_ready low for three cycles mid-burst.
        do_reset();
        begin
            int  k = 0;
            logic a, done;
            done = 1'b0;
            for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, (i == 4), 8'(i + 1)});
            for (int cyc = 0; cyc < 40 && !done; cyc++) begin
                in0_valid = (k < 5); in0_data = 8'(k + 1); in0_last = (k == 4);
                out_ready = !(cyc >= 4 && cyc <= 6);
                #1;
                if (!out_ready) begin
                    check($sformatf("stall%0d out_valid", cyc), out_valid, 1'b1);
                    check($sformatf("stall%0d out_data", cyc),  out_data,  8'h03);
                    check($sformatf("stall%0d out_last", cyc),  out_last,  1'b0);
                    check($sformatf("stall%0d out_src", cyc),   out_src,   1'b0);
                    check($sformatf("stall%0d in0_ready", cyc), in0_ready, 1'b0);
                end
                if (out_valid && out_ready) got_q.push_back({out_src, out_last, out_data});
                a = in0_valid && in0_ready;
                if (k == 5 && !out_valid) done = 1'b1;
                @(negedge clk);
                if (a) k++;
            end
            out_ready = 1'b1;
            check("stall finished", done, 1'b1);
            score("stall");
        end

        // Reset during the second beat of a GRANT1 burst.
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h31; in1_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in1_data = 8'h32;
        #1;
        check("pre-reset out_valid", out_valid, 1'b1);
        check("pre-reset out_data", out_data, 8'h31);
        check("pre-reset out_src", out_src, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async reset out_valid", out_valid, 1'b0);
        check("async reset out_data", out_data, 8'h00);
        check("async reset out_src", out_src, 1'b0);
        check("async reset in1_ready", in1_ready, 1'b0);
        check("async reset busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        in1_valid = 1'b0; in1_last = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b1;
        begin
            logic seen, a;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                #1;
                if (out_valid) begin
                    seen = 1'b1;
                    check("post-reset out_src", out_src, 1'b0);
                    check("post-reset out_data", out_data, 8'h55);
                    check("post-reset out_last", out_last, 1'b1);
                end
                a = in0_valid && in0_ready;
                @(negedge clk);
                if (a) in0_valid = 1'b0;
            end
            check("post-reset beat seen", seen, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
